// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU decode/issue boundary.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_func_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_SKID
    } issue_state_t;

    localparam logic [6:0] OP_R        = 7'b0110011;
    localparam logic [6:0] OP_I        = 7'b0010011;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
    localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
    localparam logic [2:0] FUNCT3_SLTU = 3'b011;

    typedef struct packed {
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] ext_imm;
        alu_func_t   alu_func;
        logic        op_b_src;
        logic        illegal;
    } issue_payload_t;

    // funct3 to ALU function for the base (funct7 = 0) encodings; SLTU has no mapping.
    function automatic alu_func_t funct3_to_alu(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_ADD;
            3'b111:  return ALU_AND;
            3'b110:  return ALU_OR;
            3'b100:  return ALU_XOR;
            3'b010:  return ALU_SLT;
            3'b001:  return ALU_SLL;
            3'b101:  return ALU_SRL;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of an instruction word into ALU control and extended immediate.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] InstrD,
    output alu_func_t   alu_func,
    output logic        op_b_src,
    output logic [31:0] ext_imm,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode        = InstrD[6:0];
    assign funct3        = InstrD[14:12];
    assign funct7        = InstrD[31:25];
    assign unused_fields = ^{InstrD[19:15], InstrD[11:7]};

    always_comb begin
        alu_func = ALU_ADD;
        op_b_src = 1'b1;
        ext_imm  = '0;
        illegal  = 1'b1;
        case (opcode)
            OP_R: begin
                if (funct7 == FUNCT7_ZERO && funct3 != FUNCT3_SLTU) begin
                    alu_func = funct3_to_alu(funct3);
                    op_b_src = 1'b0;
                    illegal  = 1'b0;
                end else if (funct7 == FUNCT7_ALT && funct3 == 3'b000) begin
                    alu_func = ALU_SUB;
                    op_b_src = 1'b0;
                    illegal  = 1'b0;
                end
            end
            OP_I: begin
                case (funct3)
                    // Shifts take a zero-extended shamt; SRAI (funct7 = ALT) stays illegal.
                    3'b001, 3'b101: begin
                        if (funct7 == FUNCT7_ZERO) begin
                            alu_func = funct3_to_alu(funct3);
                            ext_imm  = {27'd0, InstrD[24:20]};
                            illegal  = 1'b0;
                        end
                    end
                    FUNCT3_SLTU: ;
                    default: begin
                        alu_func = funct3_to_alu(funct3);
                        ext_imm  = {{20{InstrD[31]}}, InstrD[31:20]};
                        illegal  = 1'b0;
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Decode-to-execute issue register with valid/ready handshake and a one-entry skid buffer.
module alu_issue
    import alu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic            flush,
    output logic            ValidE,
    input  logic            ex_ready,
    output logic [XLEN-1:0] OpA,
    output logic [XLEN-1:0] OpB,
    output logic [XLEN-1:0] ExtImmE,
    output logic [2:0]      ALUFuncE,
    output logic            OpBSrcE,
    output logic            IllegalE
);

    issue_state_t   state_q, state_d;
    issue_payload_t e_q, s_q, dec_pay;
    alu_func_t      dec_func;
    logic           dec_src, dec_ill;
    logic [31:0]    dec_imm;
    logic           rdy_q;
    logic           accept, out_xfer;
    logic           load_e_in, load_e_skid, load_s;

    alu_decode u_decode (
        .InstrD   (InstrD),
        .alu_func (dec_func),
        .op_b_src (dec_src),
        .ext_imm  (dec_imm),
        .illegal  (dec_ill)
    );

    always_comb begin
        dec_pay = '{op_a: RD1D, op_b: RD2D, ext_imm: dec_imm,
                    alu_func: dec_func, op_b_src: dec_src, illegal: dec_ill};
    end

    assign accept   = in_valid && in_ready && !flush;
    assign out_xfer = ValidE && ex_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= SKID_EN ? (state_d != ST_SKID) : 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_FULL;
                ST_FULL: begin
                    if (out_xfer && !accept)
                        state_d = ST_EMPTY;
                    else if (!out_xfer && accept && SKID_EN)
                        state_d = ST_SKID;
                end
                ST_SKID:  if (out_xfer) state_d = ST_FULL;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Without the skid entry, ready looks through to ex_ready so E is never overwritten.
    always_comb begin
        ValidE      = (state_q != ST_EMPTY);
        in_ready    = SKID_EN ? rdy_q : (rdy_q && (ex_ready || !ValidE));
        load_e_in   = accept && (state_q == ST_EMPTY || (state_q == ST_FULL && out_xfer));
        load_s      = accept && state_q == ST_FULL && !out_xfer;
        load_e_skid = !flush && state_q == ST_SKID && out_xfer;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            e_q <= '0;
            s_q <= '0;
        end else begin
            if (load_e_in)
                e_q <= dec_pay;
            else if (load_e_skid)
                e_q <= s_q;
            if (load_s)
                s_q <= dec_pay;
        end
    end

    assign OpA      = e_q.op_a;
    assign OpB      = e_q.op_b;
    assign ExtImmE  = e_q.ext_imm;
    assign ALUFuncE = e_q.alu_func;
    assign OpBSrcE  = e_q.op_b_src;
    assign IllegalE = e_q.illegal;

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Decode/execute boundary block: the producer end of the ALU control interface.
- Accepts a decoded-stage instruction plus its register-file read data, and generates ALU control (ALUFuncE, OpBSrcE), ExtImmE and operands.
- Registers these into the execute stage through a valid/ready pipeline register backed by a one-entry skid buffer, so that the decode ready signal is registered.
- Supports a synchronous flush from branch/hazard logic.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- SKID_EN, 1, 1 = one-entry skid buffer present; 0 = in_ready is ex_ready || !ValidE (combinational path).

Ports:
- clk  input  1  core clock, rising edge
- reset_n  input  1  synchronous active-low reset
- in_valid  input  1  decode presents an instruction
- in_ready  output  1  issue can accept this cycle
- InstrD  input  32  raw instruction word
- RD1D  input  32  rs1 read data
- RD2D  input  32  rs2 read data
- flush  input  1  discard all held and incoming instructions
- ValidE  output  1  execute-stage payload valid
- ex_ready  input  1  execute consumes payload this cycle
- OpA  output  32  operand A (RD1D)
- OpB  output  32  operand B register value (RD2D)
- ExtImmE  output  32  extended immediate
- ALUFuncE  output  3  ALU function code
- OpBSrcE  output  1  1 = use ExtImmE as operand B, 0 = use OpB
- IllegalE  output  1  payload is an unsupported instruction; ALU fields forced to ADD with ExtImmE = 0

Behaviour:
- Decode (combinational on InstrD)
  - opcode 0110011 (R-type), OpBSrc = 0:
    - funct7 = 0000000 with funct3 000/111/110/100/010/001/101 → ADD 000, AND 010, OR 011, XOR 100, SLT 101, SLL 110, SRL 111.
    - funct7 = 0100000 with funct3 000 → SUB 001.
  - opcode 0010011 (I-type), OpBSrc = 1:
    - ADDI, ANDI, ORI, XORI, SLTI use the same funct3 map.
    - ExtImm = sign-extended InstrD[31:20].
  - SLLI/SRLI: require InstrD[31:25] = 0000000; ExtImm = zero-extended shamt InstrD[24:20].
  - Everything else is illegal, including SRA, SRAI, SLTU, SLTIU, other opcodes and bad funct7: IllegalE = 1, ALUFunc = 000, OpBSrc = 1, ExtImm = 0.
- Handshake
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when ValidE && ex_ready.
  - Latency from input transfer to ValidE is 1 cycle when the stage is empty or draining.
- State (two valid bits: E, S)
  - EMPTY (E=0, S=0): accept → FULL.
  - FULL (E=1, S=0):
    - out-transfer with accept → FULL (new payload).
    - out-transfer without accept → EMPTY.
    - no out-transfer with accept → SKID (payload goes to skid).
  - SKID (E=1, S=1): in_ready = 0. On out-transfer, the skid payload moves to E → FULL.
- in_ready = !S (registered).
- Flush
  - Synchronous, highest priority: E and S are cleared and the same-cycle input is dropped.
  - in_ready = 1 the next cycle.
  - Payload registers are not cleared.
- Simultaneous flush and ex_ready: the flush wins. The consumer must ignore the transfer; execute treats flush as killing ValidE.
- Reset (reset_n = 0 at a rising edge)
  - ValidE = 0, S = 0.
  - OpA, OpB, ExtImmE = 0; ALUFuncE = 000; OpBSrcE = 0; IllegalE = 0.
  - in_ready = 0 while reset_n is low, 1 from the first cycle after release.
  - Reset mid-SKID discards both entries.
- Payload registers load only on their transfer. Outputs are stable while ValidE && !ex_ready.
- SKID_EN = 0: S is absent. Accept is allowed only when E will be free; there is no back-to-back loss.

Decomposition:
- Shared package alu_pkg:
  - enum alu_func_t (ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101, SLL 110, SRL 111).
  - opcode constants OP_R = 7'b0110011, OP_I = 7'b0010011.
  - FUNCT7_ALT = 7'b0100000.
  - struct issue_payload_t (OpA, OpB, ExtImm, ALUFunc, OpBSrc, Illegal).
- Sub-module alu_decode: purely combinational InstrD → ALUFunc/OpBSrc/ExtImm/Illegal.
- alu_issue holds the handshake FSM and the two payload registers.

Test Plan:
- add x3,x1,x2 (0x002081B3), RD1D = 5, RD2D = 7, ex_ready = 1 → next cycle ValidE = 1, ALUFuncE = 000, OpBSrcE = 0, OpA = 5, OpB = 7, IllegalE = 0.
- sub (0x402081B3) → ALUFuncE = 001, OpBSrcE = 0. addi x1,x0,-5 (0xFFB00093) → ALUFuncE = 000, OpBSrcE = 1, ExtImmE = 0xFFFFFFFB.
- slli x5,x5,3 (0x00329293) → ALUFuncE = 110, ExtImmE = 0x00000003. srai (0x4032D293) → IllegalE = 1, ALUFuncE = 000, ExtImmE = 0.
- Backpressure:
  - ex_ready = 0 with three back-to-back in_valid instructions A, B, C.
  - A is held on the outputs, B goes to skid, in_ready = 0, C is stalled.
  - Raise ex_ready → outputs B then C on consecutive cycles; no loss and no duplication.
- Flush in SKID state with in_valid = 1 → next cycle ValidE = 0, in_ready = 1; the dropped instruction never appears.
- Reset asserted in FULL → next edge ValidE = 0, all payload outputs 0, in_ready = 0. After release in_ready = 1 and the first accepted instruction appears 1 cycle later.
